// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// ALU operation selects and ALU B-operand selects.
package mc_control_unit_pkg;

  localparam int MC_OPW = 4;
  localparam int MC_ACW = 3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXECUTE  = 4'd2,
    S_ALUWB    = 4'd3,
    S_MEMADR   = 4'd4,
    S_MEMREAD  = 4'd5,
    S_MEMWB    = 4'd6,
    S_MEMWRITE = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDR  = 4'h9;
  localparam logic [3:0] OP_STR  = 4'hA;
  localparam logic [3:0] OP_B    = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_LSL   = 3'b101;
  localparam logic [2:0] ALU_LSR   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// Combinational map from (state, opcode) to ALU operation and B-operand select.
module mc_alu_decoder
  import mc_control_unit_pkg::*;
#(
  parameter int OPW = MC_OPW,
  parameter int ACW = MC_ACW
) (
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  output logic [ACW-1:0] alu_control,
  output logic [1:0]     alu_src_b
);

  always_comb begin
    alu_control = ALU_ADD;
    alu_src_b   = SRCB_ONE;
    case (state)
      // DECODE precomputes the branch target; MEMADR forms base + offset
      S_DECODE, S_MEMADR: alu_src_b = SRCB_IMM;
      S_EXECUTE: begin
        alu_src_b = SRCB_REG;
        if (!opcode[OPW-1])        alu_control = opcode[ACW-1:0];
        else if (opcode == OP_ADDI) alu_src_b  = SRCB_IMM;
        else if (opcode == OP_CMP)  alu_control = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle controller: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and write enables, and holds the architectural flags.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int OPW = MC_OPW,
  parameter int ACW = MC_ACW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  input  logic           c,
  input  logic           v,
  input  logic           n,
  input  logic           z,
  output logic [ACW-1:0] alu_control,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic           pc_src,
  output logic           i_or_d,
  output logic           wd_sel,
  output logic           pc_write,
  output logic           ir_write,
  output logic           mem_write,
  output logic           reg_write,
  output logic [3:0]     flags_q,
  output logic           halted
);

  state_t state;
  state_t out_state;
  logic   taken;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      flags_q <= '0;
    end else begin
      if (state == S_EXECUTE) flags_q <= {c, v, n, z};
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (!opcode[OPW-1] || opcode == OP_ADDI || opcode == OP_CMP)
            state <= S_EXECUTE;
          else if (opcode == OP_LDR || opcode == OP_STR)
            state <= S_MEMADR;
          else if (opcode == OP_HALT)
            state <= S_HALT;
          else
            state <= S_BRANCH;
        end
        S_EXECUTE:  state <= (opcode == OP_CMP) ? S_FETCH : S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_MEMADR:   state <= (opcode == OP_LDR) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // While reset is held, outputs show FETCH values regardless of the
  // (possibly mid-instruction) state register.
  assign out_state = reset ? state : S_FETCH;

  mc_alu_decoder #(.OPW(OPW), .ACW(ACW)) u_alu_dec (
    .state       (out_state),
    .opcode      (opcode),
    .alu_control (alu_control),
    .alu_src_b   (alu_src_b)
  );

  // Branch resolution looks only at the registered Z flag.
  always_comb begin
    case (opcode)
      OP_B:    taken = 1'b1;
      OP_BEQ:  taken = flags_q[0];
      OP_BNE:  taken = !flags_q[0];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_src_a = 1'b0;
    pc_src    = 1'b0;
    i_or_d    = 1'b0;
    wd_sel    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;
    case (out_state)
      // FETCH is the only state reachable from out_state under reset
      S_FETCH: begin
        pc_write = reset & mem_ready;
        ir_write = reset & mem_ready;
      end
      S_EXECUTE, S_MEMADR: alu_src_a = 1'b1;
      S_ALUWB:    reg_write = 1'b1;
      S_MEMREAD:  i_or_d = 1'b1;
      S_MEMWB: begin
        reg_write = 1'b1;
        wd_sel    = 1'b1;
      end
      S_MEMWRITE: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        pc_src   = 1'b1;
        pc_write = taken;
      end
      S_HALT:     halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  typedef struct packed {
    logic [2:0] ac;
    logic       sa;
    logic [1:0] sb;
    logic       ps;
    logic       iod;
    logic       wd;
    logic       pw;
    logic       iw;
    logic       mw;
    logic       rw;
    logic [3:0] fl;
    logic       h;
  } cw_t;

  typedef struct {
    string nm;
    cw_t   e;
    cw_t   m;
  } chk_t;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       c, v, n, z;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_src, i_or_d, wd_sel;
  logic       pc_write, ir_write, mem_write, reg_write;
  logic [3:0] flags_q;
  logic       halted;

  cw_t  act;
  chk_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mc_control_unit #(.OPW(4), .ACW(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .c(c), .v(v), .n(n), .z(z),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .i_or_d(i_or_d), .wd_sel(wd_sel),
    .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .flags_q(flags_q), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {alu_control, alu_src_a, alu_src_b, pc_src, i_or_d, wd_sel,
                pc_write, ir_write, mem_write, reg_write, flags_q, halted};

  function automatic cw_t mk(logic [2:0] ac, logic sa, logic [1:0] sb, logic ps,
                             logic iod, logic wd, logic pw, logic iw, logic mw,
                             logic rw, logic [3:0] fl, logic h);
    cw_t r;
    r = {ac, sa, sb, ps, iod, wd, pw, iw, mw, rw, fl, h};
    return r;
  endfunction

  function automatic chk_t e_fetch(string nm, logic pw, logic [3:0] fl);
    chk_t k;
    k.nm = nm;
    k.e  = mk(ALU_ADD, 0, SRCB_ONE, 0, 0, 0, pw, pw, 0, 0, fl, 0);
    k.m  = mk(3'h7, 1, 2'h3, 1, 1, 0, 1, 1, 1, 1, 4'hF, 1);
    return k;
  endfunction

  function automatic chk_t e_dec(string nm, logic [3:0] fl);
    chk_t k;
    k.nm = nm;
    k.e  = mk(ALU_ADD, 0, SRCB_IMM, 0, 0, 0, 0, 0, 0, 0, fl, 0);
    k.m  = mk(3'h7, 1, 2'h3, 0, 0, 0, 1, 1, 1, 1, 4'hF, 1);
    return k;
  endfunction

  function automatic chk_t e_exe(string nm, logic [2:0] ac, logic [1:0] sb, logic [3:0] fl);
    chk_t k;
    k.nm = nm;
    k.e  = mk(ac, 1, sb, 0, 0, 0, 0, 0, 0, 0, fl, 0);
    k.m  = mk(3'h7, 1, 2'h3, 0, 0, 0, 1, 1, 1, 1, 4'hF, 1);
    return k;
  endfunction

  function automatic chk_t e_madr(string nm, logic [3:0] fl);
    chk_t k;
    k.nm = nm;
    k.e  = mk(ALU_ADD, 1, SRCB_IMM, 0, 0, 0, 0, 0, 0, 0, fl, 0);
    k.m  = mk(3'h7, 1, 2'h3, 0, 0, 0, 1, 1, 1, 1, 4'hF, 1);
    return k;
  endfunction

  function automatic chk_t e_wb(string nm, logic wd, logic [3:0] fl);
    chk_t k;
    k.nm = nm;
    k.e  = mk(0, 0, 0, 0, 0, wd, 0, 0, 0, 1, fl, 0);
    k.m  = mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 4'hF, 1);
    return k;
  endfunction

  function automatic chk_t e_mem(string nm, logic mw, logic [3:0] fl);
    chk_t k;
    k.nm = nm;
    k.e  = mk(0, 0, 0, 0, 1, 0, 0, 0, mw, 0, fl, 0);
    k.m  = mk(0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 4'hF, 1);
    return k;
  endfunction

  function automatic chk_t e_br(string nm, logic pw, logic [3:0] fl);
    chk_t k;
    k.nm = nm;
    k.e  = mk(0, 0, 0, 1, 0, 0, pw, 0, 0, 0, fl, 0);
    k.m  = mk(0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 4'hF, 1);
    return k;
  endfunction

  function automatic chk_t e_halt(string nm, logic [3:0] fl);
    chk_t k;
    k.nm = nm;
    k.e  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fl, 1);
    k.m  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 4'hF, 1);
    return k;
  endfunction

  task automatic cyc(input logic rst, input logic [3:0] op, input logic mr,
                     input logic [3:0] af, input chk_t k);
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    mem_ready = mr;
    {c, v, n, z} = af;
    q.push_back(k);
  endtask

  initial begin : monitor
    chk_t k;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        k = q.pop_front();
        n_cmp++;
        if (((act ^ k.e) & k.m) !== '0) begin
          n_bad++;
          $display("FAIL %s: got %05h want %05h (mask %05h)", k.nm, act & k.m, k.e & k.m, k.m);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b0; opcode = 4'h0; mem_ready = 1'b1; {c, v, n, z} = 4'b0000;

    cyc(0, 4'h0, 1, 4'h0, e_fetch("rst_0", 0, 4'h0));
    cyc(0, 4'h0, 1, 4'h0, e_fetch("rst_1", 0, 4'h0));

    cyc(1, 4'h1, 1, 4'h0, e_fetch("sub_fetch", 1, 4'h0));
    cyc(1, 4'h1, 1, 4'h0, e_dec("sub_dec", 4'h0));
    cyc(1, 4'h1, 1, 4'b0001, e_exe("sub_exe", ALU_SUB, SRCB_REG, 4'h0));
    cyc(1, 4'h1, 1, 4'h0, e_wb("sub_wb", 0, 4'b0001));

    cyc(1, 4'hE, 1, 4'h0, e_fetch("cmp1_fetch", 1, 4'b0001));
    cyc(1, 4'hE, 1, 4'h0, e_dec("cmp1_dec", 4'b0001));
    cyc(1, 4'hE, 1, 4'b0001, e_exe("cmp1_exe", ALU_SUB, SRCB_REG, 4'b0001));
    cyc(1, 4'hC, 1, 4'h0, e_fetch("beq1_fetch", 1, 4'b0001));
    cyc(1, 4'hC, 1, 4'h0, e_dec("beq1_dec", 4'b0001));
    cyc(1, 4'hC, 1, 4'hF, e_br("beq_taken", 1, 4'b0001));

    cyc(1, 4'hE, 1, 4'h0, e_fetch("cmp2_fetch", 1, 4'b0001));
    cyc(1, 4'hE, 1, 4'h0, e_dec("cmp2_dec", 4'b0001));
    cyc(1, 4'hE, 1, 4'b1000, e_exe("cmp2_exe", ALU_SUB, SRCB_REG, 4'b0001));
    cyc(1, 4'hC, 1, 4'h0, e_fetch("beq2_fetch", 1, 4'b1000));
    cyc(1, 4'hC, 1, 4'h0, e_dec("beq2_dec", 4'b1000));
    cyc(1, 4'hC, 1, 4'h1, e_br("beq_not_taken", 0, 4'b1000));
    cyc(1, 4'hD, 1, 4'h0, e_fetch("bne_fetch", 1, 4'b1000));
    cyc(1, 4'hD, 1, 4'h0, e_dec("bne_dec", 4'b1000));
    cyc(1, 4'hD, 1, 4'h1, e_br("bne_taken", 1, 4'b1000));
    cyc(1, 4'hB, 1, 4'h0, e_fetch("b_fetch", 1, 4'b1000));
    cyc(1, 4'hB, 1, 4'h0, e_dec("b_dec", 4'b1000));
    cyc(1, 4'hB, 1, 4'h0, e_br("b_taken", 1, 4'b1000));

    cyc(1, 4'h4, 1, 4'h0, e_fetch("xor_fetch", 1, 4'b1000));
    cyc(1, 4'h4, 1, 4'h0, e_dec("xor_dec", 4'b1000));
    cyc(1, 4'h4, 1, 4'b0010, e_exe("xor_exe", ALU_XOR, SRCB_REG, 4'b1000));
    cyc(1, 4'h4, 1, 4'h0, e_wb("xor_wb", 0, 4'b0010));
    cyc(1, 4'h8, 1, 4'h0, e_fetch("addi_fetch", 1, 4'b0010));
    cyc(1, 4'h8, 1, 4'h0, e_dec("addi_dec", 4'b0010));
    cyc(1, 4'h8, 1, 4'b0100, e_exe("addi_exe", ALU_ADD, SRCB_IMM, 4'b0010));
    cyc(1, 4'h8, 1, 4'h0, e_wb("addi_wb", 0, 4'b0100));

    cyc(1, 4'h9, 1, 4'hF, e_fetch("ldr_fetch", 1, 4'b0100));
    cyc(1, 4'h9, 1, 4'hF, e_dec("ldr_dec", 4'b0100));
    cyc(1, 4'h9, 1, 4'hF, e_madr("ldr_madr", 4'b0100));
    cyc(1, 4'h9, 0, 4'hF, e_mem("ldr_rd_w0", 0, 4'b0100));
    cyc(1, 4'h9, 0, 4'hF, e_mem("ldr_rd_w1", 0, 4'b0100));
    cyc(1, 4'h9, 0, 4'hF, e_mem("ldr_rd_w2", 0, 4'b0100));
    cyc(1, 4'h9, 1, 4'hF, e_mem("ldr_rd_done", 0, 4'b0100));
    cyc(1, 4'h9, 1, 4'hF, e_wb("ldr_wb", 1, 4'b0100));

    cyc(1, 4'hA, 0, 4'h0, e_fetch("str_fetch_wait", 0, 4'b0100));
    cyc(1, 4'hA, 1, 4'h0, e_fetch("str_fetch", 1, 4'b0100));
    cyc(1, 4'hA, 1, 4'h0, e_dec("str_dec", 4'b0100));
    cyc(1, 4'hA, 1, 4'h0, e_madr("str_madr", 4'b0100));
    cyc(1, 4'hA, 0, 4'h0, e_mem("str_mwr", 1, 4'b0100));
    cyc(0, 4'hA, 1, 4'h0, e_fetch("str_reset", 0, 4'b0100));

    cyc(1, 4'hF, 1, 4'h0, e_fetch("post_rst_fetch", 1, 4'h0));
    cyc(1, 4'hF, 1, 4'h0, e_dec("halt_dec", 4'h0));
    for (int i = 0; i < 20; i++)
      cyc(1, 4'hF, 1, 4'($urandom_range(0, 15)), e_halt("halt_hold", 4'h0));
    cyc(0, 4'hF, 1, 4'h0, e_fetch("halt_reset", 0, 4'h0));

    cyc(1, 4'hA, 1, 4'h0, e_fetch("halt_exit_fetch", 1, 4'h0));
    cyc(1, 4'hA, 1, 4'h0, e_dec("str2_dec", 4'h0));
    cyc(1, 4'hA, 1, 4'h0, e_madr("str2_madr", 4'h0));
    cyc(1, 4'hA, 1, 4'h0, e_mem("str2_mwr", 1, 4'h0));
    cyc(1, 4'h0, 0, 4'h0, e_fetch("str2_done_fetch", 0, 4'h0));

    @(negedge clk);
    #1;
    n_cmp++;
    if (pc_write !== 1'b0 || ir_write !== 1'b0) begin
      n_bad++;
      $display("FAIL final_fetch_wait: pc_write=%b ir_write=%b", pc_write, ir_write);
    end
    n_cmp++;
    if (i_or_d !== 1'b0 || alu_src_b !== SRCB_ONE || alu_control !== ALU_ADD) begin
      n_bad++;
      $display("FAIL final_fetch_sel: i_or_d=%b alu_src_b=%b alu_control=%b",
               i_or_d, alu_src_b, alu_control);
    end
    n_cmp++;
    if (flags_q !== 4'h0) begin
      n_bad++;
      $display("FAIL final_flags: flags_q=%b", flags_q);
    end
    n_cmp++;
    if (halted !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
      n_bad++;
      $display("FAIL final_enables: halted=%b mem_write=%b reg_write=%b",
               halted, mem_write, reg_write);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad != 0) begin
      $display("TEST FAILED");
      $fatal(1);
    end
    $display("TEST PASSED");
    $finish;
  end

endmodule
